// File: rtl/vx_dispatch_split.sv
// Splits one issued warp instruction into NUM_THREADS/NUM_LANES execute packets,
// skipping batches with an empty thread-mask slice, behind a registered output stage.
module vx_dispatch_lane #(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int PID_WIDTH   = 2,
    parameter int LANE        = 0
) (
    input  logic [PID_WIDTH-1:0]              pid_i,
    input  logic [NUM_THREADS-1:0]            tmask_i,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]  rs1_i,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]  rs2_i,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]  rs3_i,
    output logic                              tmask_o,
    output logic [XLEN-1:0]                   rs1_o,
    output logic [XLEN-1:0]                   rs2_o,
    output logic [XLEN-1:0]                   rs3_o
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic [TW-1:0] idx;

    assign idx     = TW'(pid_i) * TW'(NUM_LANES) + TW'(LANE);
    assign tmask_o = tmask_i[idx];
    assign rs1_o   = rs1_i[idx];
    assign rs2_o   = rs2_i[idx];
    assign rs3_o   = rs3_i[idx];
endmodule

module vx_dispatch_split #(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int NW_WIDTH    = 2,
    parameter int UUID_WIDTH  = 44,
    parameter int PC_BITS     = 30,
    parameter int NR_BITS     = 6,
    parameter int OP_BITS     = 4,
    parameter int ARGS_BITS   = 16,
    parameter int VL_WIDTH    = 1,
    localparam int NUM_PIDS   = NUM_THREADS / NUM_LANES,
    localparam int PID_WIDTH  = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [UUID_WIDTH-1:0]             in_uuid_i,
    input  logic [VL_WIDTH-1:0]               in_lid_i,
    input  logic [NW_WIDTH-1:0]               in_wid_i,
    input  logic [PC_BITS-1:0]                in_pc_i,
    input  logic [OP_BITS-1:0]                in_op_type_i,
    input  logic [ARGS_BITS-1:0]              in_op_args_i,
    input  logic                              in_wb_i,
    input  logic [NR_BITS-1:0]                in_rd_i,
    input  logic [NUM_THREADS-1:0]            in_tmask_i,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]  in_rs1_data_i,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]  in_rs2_data_i,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]  in_rs3_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [UUID_WIDTH-1:0]             out_uuid_o,
    output logic [VL_WIDTH-1:0]               out_lid_o,
    output logic [NW_WIDTH-1:0]               out_wid_o,
    output logic [PC_BITS-1:0]                out_pc_o,
    output logic [OP_BITS-1:0]                out_op_type_o,
    output logic [ARGS_BITS-1:0]              out_op_args_o,
    output logic                              out_wb_o,
    output logic [NR_BITS-1:0]                out_rd_o,
    output logic [NUM_LANES-1:0]              out_tmask_o,
    output logic [NUM_LANES-1:0][XLEN-1:0]    out_rs1_data_o,
    output logic [NUM_LANES-1:0][XLEN-1:0]    out_rs2_data_o,
    output logic [NUM_LANES-1:0][XLEN-1:0]    out_rs3_data_o,
    output logic [PID_WIDTH-1:0]              out_pid_o,
    output logic                              out_sop_o,
    output logic                              out_eop_o
);
    typedef struct packed {
        logic [UUID_WIDTH-1:0] uuid;
        logic [VL_WIDTH-1:0]   lid;
        logic [NW_WIDTH-1:0]   wid;
        logic [PC_BITS-1:0]    pc;
        logic [OP_BITS-1:0]    op_type;
        logic [ARGS_BITS-1:0]  op_args;
        logic                  wb;
        logic [NR_BITS-1:0]    rd;
    } meta_t;

    typedef enum logic {IDLE, SPLIT} state_e;

    state_e                           state_q, state_d;
    logic [PID_WIDTH-1:0]             cur_pid_q, cur_pid_d;
    logic [NUM_PIDS-1:0]              active;
    logic [PID_WIDTH-1:0]             sel;
    logic                             more;
    logic                             load_slot, load, eop;

    meta_t                            in_meta, meta_q;
    logic                             out_valid_q, sop_q, eop_q;
    logic [PID_WIDTH-1:0]             pid_q;
    logic [NUM_LANES-1:0]             lane_tmask, tmask_q;
    logic [NUM_LANES-1:0][XLEN-1:0]   lane_rs1, lane_rs2, lane_rs3;
    logic [NUM_LANES-1:0][XLEN-1:0]   rs1_q, rs2_q, rs3_q;

    assign in_meta = '{uuid: in_uuid_i, lid: in_lid_i, wid: in_wid_i, pc: in_pc_i,
                       op_type: in_op_type_i, op_args: in_op_args_i, wb: in_wb_i, rd: in_rd_i};

    for (genvar b = 0; b < NUM_PIDS; b++) begin : g_active
        assign active[b] = |in_tmask_i[b*NUM_LANES +: NUM_LANES];
    end

    // An all-zero mask falls through with sel=0 and no batch above it, giving the lone sop+eop packet.
    always_comb begin
        sel  = '0;
        more = 1'b0;
        for (int b = NUM_PIDS - 1; b >= 0; b--) begin
            if (active[b] && b >= int'(cur_pid_q)) sel = PID_WIDTH'(b);
        end
        for (int b = 0; b < NUM_PIDS; b++) begin
            if (active[b] && b > int'(sel)) more = 1'b1;
        end
    end

    assign load_slot  = !out_valid_q || out_ready_i;
    assign load       = load_slot && in_valid_i;
    assign eop        = !more;
    assign in_ready_o = load && eop;

    always_comb begin
        state_d   = state_q;
        cur_pid_d = cur_pid_q;
        if (load) begin
            if (eop) begin
                state_d   = IDLE;
                cur_pid_d = '0;
            end else begin
                state_d   = SPLIT;
                cur_pid_d = sel + PID_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cur_pid_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_pid_q <= cur_pid_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vx_dispatch_lane #(
            .NUM_THREADS (NUM_THREADS),
            .NUM_LANES   (NUM_LANES),
            .XLEN        (XLEN),
            .PID_WIDTH   (PID_WIDTH),
            .LANE        (l)
        ) u_lane (
            .pid_i   (sel),
            .tmask_i (in_tmask_i),
            .rs1_i   (in_rs1_data_i),
            .rs2_i   (in_rs2_data_i),
            .rs3_i   (in_rs3_data_i),
            .tmask_o (lane_tmask[l]),
            .rs1_o   (lane_rs1[l]),
            .rs2_o   (lane_rs2[l]),
            .rs3_o   (lane_rs3[l])
        );
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_valid_q <= 1'b0;
            meta_q      <= '0;
            tmask_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs3_q       <= '0;
            pid_q       <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            if (load_slot) out_valid_q <= in_valid_i;
            if (load) begin
                meta_q  <= in_meta;
                tmask_q <= lane_tmask;
                rs1_q   <= lane_rs1;
                rs2_q   <= lane_rs2;
                rs3_q   <= lane_rs3;
                pid_q   <= sel;
                sop_q   <= (state_q == IDLE);
                eop_q   <= eop;
            end
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_uuid_o     = meta_q.uuid;
    assign out_lid_o      = meta_q.lid;
    assign out_wid_o      = meta_q.wid;
    assign out_pc_o       = meta_q.pc;
    assign out_op_type_o  = meta_q.op_type;
    assign out_op_args_o  = meta_q.op_args;
    assign out_wb_o       = meta_q.wb;
    assign out_rd_o       = meta_q.rd;
    assign out_tmask_o    = tmask_q;
    assign out_rs1_data_o = rs1_q;
    assign out_rs2_data_o = rs2_q;
    assign out_rs3_data_o = rs3_q;
    assign out_pid_o      = pid_q;
    assign out_sop_o      = sop_q;
    assign out_eop_o      = eop_q;

    // The split indexes the held input, so the instruction must stay presented until eop loads.
    a_hold_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   (state_q == SPLIT) |-> in_valid_i);
endmodule
